// File: rtl/bulk_frame_pkg.sv
// bulk_frame_pkg: shared types and constants for the bulk_tx framer.
//   frame_state_e   : serializer state encoding
//   HEADER_DEFAULT  : frame start byte
//   BYTES_PER_FRAME : header + address + data bytes + checksum
package bulk_frame_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    ADDR,
    DATA,
    SUM
  } frame_state_e;

  localparam logic [7:0] HEADER_DEFAULT     = 8'hA5;
  localparam int         DATA_WIDTH_DEFAULT = 32;
  localparam int         BYTES_PER_FRAME    = 2 + DATA_WIDTH_DEFAULT / 8 + 1;

endpackage

// File: rtl/w_busif.sv
// w_busif: write-bus handshake carrying one {addr, data} update word.
//   data, addr, valid : driven by master
//   ready             : driven by slave
interface w_busif #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  valid;
  logic                  ready;

  modport master (output data, output addr, output valid, input ready);
  modport slave  (input data, input addr, input valid, output ready);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, show-ahead read (rdata is the head entry).
//   clk, rstn     : clock, synchronous active-low reset
//   push, wdata   : write strobe and word
//   pop, rdata    : read strobe and head word
//   full, empty   : occupancy flags
//   count         : entries held
module sync_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // Storage needs no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
endmodule

// File: rtl/bulk_tx_framer.sv
// bulk_tx_framer: buffers {addr, data} update words and serializes each into
// a frame  HEADER, addr, data MSB-first, XOR(addr, data bytes)  for a UART
// byte transmitter.
//   clk, rstn          : clock, synchronous active-low reset
//   bulk_in (slave)    : update word input with valid/ready
//   tx_data, tx_valid  : byte to transmitter, held until tx_ready
//   tx_ready           : transmitter accepts byte
//   busy               : words queued or frame in progress
//   frame_cnt          : completed frames, wrapping
module bulk_tx_framer
  import bulk_frame_pkg::*;
#(
  parameter int         DATA_WIDTH = 32,
  parameter int         ADDR_WIDTH = 8,
  parameter int         FIFO_DEPTH = 8,
  parameter logic [7:0] HEADER     = HEADER_DEFAULT
) (
  input  logic        clk,
  input  logic        rstn,
  w_busif.slave       bulk_in,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic [15:0] frame_cnt
);
  localparam int NB   = DATA_WIDTH / 8;
  localparam int IDXW = (NB > 1) ? $clog2(NB) : 1;
  localparam int CW   = $clog2(FIFO_DEPTH) + 1;
  localparam int FW   = ADDR_WIDTH + DATA_WIDTH;

  frame_state_e          state, state_n;
  logic [7:0]            tx_data_n, chk, chk_n;
  logic                  tx_valid_n, busy_n, ready_q;
  logic [IDXW-1:0]       idx, idx_n;
  logic [ADDR_WIDTH-1:0] frame_addr, frame_addr_n;
  logic [DATA_WIDTH-1:0] frame_data, frame_data_n;
  logic [15:0]           frame_cnt_n;

  logic                  push, pop, full, empty;
  logic [FW-1:0]         head;
  logic [CW-1:0]         count, count_nxt;

  // full is redundant with ready_q but guards against an early push.
  assign push = bulk_in.valid & ready_q & ~full;
  assign bulk_in.ready = ready_q;

  sync_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .wdata ({bulk_in.addr, bulk_in.data}),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign count_nxt = count + CW'(push) - CW'(pop);

  function automatic logic [7:0] data_byte(input logic [DATA_WIDTH-1:0] d,
                                           input logic [IDXW-1:0] i);
    logic [DATA_WIDTH-1:0] s;
    s = d << (8 * i);
    return s[DATA_WIDTH-1 -: 8];
  endfunction

  always_comb begin
    state_n      = state;
    tx_data_n    = tx_data;
    tx_valid_n   = tx_valid;
    chk_n        = chk;
    idx_n        = idx;
    frame_addr_n = frame_addr;
    frame_data_n = frame_data;
    frame_cnt_n  = frame_cnt;
    pop          = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop          = 1'b1;
          frame_addr_n = head[FW-1 -: ADDR_WIDTH];
          frame_data_n = head[DATA_WIDTH-1:0];
          chk_n        = '0;
          tx_data_n    = HEADER;
          tx_valid_n   = 1'b1;
          state_n      = HDR;
        end
      end
      HDR: if (tx_ready) begin
        tx_data_n = frame_addr;
        chk_n     = chk ^ frame_addr;
        state_n   = ADDR;
      end
      ADDR: if (tx_ready) begin
        tx_data_n = data_byte(frame_data, '0);
        chk_n     = chk ^ data_byte(frame_data, '0);
        idx_n     = '0;
        state_n   = DATA;
      end
      DATA: if (tx_ready) begin
        if (idx != IDXW'(NB - 1)) begin
          idx_n     = idx + 1'b1;
          tx_data_n = data_byte(frame_data, idx + 1'b1);
          chk_n     = chk ^ data_byte(frame_data, idx + 1'b1);
        end else begin
          // chk already folds in the byte currently on the line
          tx_data_n = chk;
          state_n   = SUM;
        end
      end
      SUM: if (tx_ready) begin
        frame_cnt_n = frame_cnt + 1'b1;
        if (!empty) begin
          pop          = 1'b1;
          frame_addr_n = head[FW-1 -: ADDR_WIDTH];
          frame_data_n = head[DATA_WIDTH-1:0];
          chk_n        = '0;
          tx_data_n    = HEADER;
          state_n      = HDR;
        end else begin
          tx_valid_n = 1'b0;
          state_n    = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (count_nxt != '0) || (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      chk        <= '0;
      idx        <= '0;
      frame_addr <= '0;
      frame_data <= '0;
      frame_cnt  <= '0;
      busy       <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state      <= state_n;
      tx_data    <= tx_data_n;
      tx_valid   <= tx_valid_n;
      chk        <= chk_n;
      idx        <= idx_n;
      frame_addr <= frame_addr_n;
      frame_data <= frame_data_n;
      frame_cnt  <= frame_cnt_n;
      busy       <= busy_n;
      ready_q    <= (count_nxt != CW'(FIFO_DEPTH));
    end
  end
endmodule

// File: tb/tb_bulk_tx_framer.sv
// tb_bulk_tx_framer: directed, table-driven bench for bulk_tx_framer.
module tb_bulk_tx_framer;
  import bulk_frame_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        busy;
  logic [15:0] frame_cnt;

  w_busif #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus ();

  bulk_tx_framer dut (
    .clk       (clk),
    .rstn      (rstn),
    .bulk_in   (bus.slave),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] byte_q [$];
  int         cyc_q  [$];
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = '0;
  int         exp_frames = 0;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    logic [7:0]  sum;
  } vec_t;
  vec_t vecs [5];

  // Transmit-side monitor: records accepted bytes and checks hold stability.
  always @(posedge clk) begin
    cyc++;
    if (rstn) begin
      if (prev_hold) begin
        checks++;
        if (!(tx_valid && tx_data == prev_data)) begin
          errors++;
          $display("FAIL hold_stable: valid=%0b data=0x%0h want valid=1 data=0x%0h",
                   tx_valid, tx_data, prev_data);
        end
      end
      if (tx_valid && tx_ready) begin
        byte_q.push_back(tx_data);
        cyc_q.push_back(cyc);
      end
      prev_hold = tx_valid && !tx_ready;
      prev_data = tx_data;
    end else begin
      prev_hold = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [7:0] a, input logic [31:0] d);
    int n;
    n = 0;
    bus.addr  = a;
    bus.data  = d;
    bus.valid = 1'b1;
    while (!bus.ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ready) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: ready=0 want 1 for addr 0x%0h", a);
    end
    @(negedge clk);
    bus.valid = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int k;
    k = 0;
    while (byte_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (byte_q.size() < n) begin
      checks++;
      errors++;
      $display("FAIL byte_timeout: got %0d bytes want %0d", byte_q.size(), n);
    end
  endtask

  function automatic logic [7:0] model_sum(input logic [7:0] a, input logic [31:0] d);
    return a ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
  endfunction

  task automatic check_frame(input string name, input logic [7:0] a,
                             input logic [31:0] d, input logic [7:0] s);
    logic [7:0] exp [7];
    logic [7:0] b;
    exp = '{HEADER_DEFAULT, a, d[31:24], d[23:16], d[15:8], d[7:0], s};
    for (int k = 0; k < BYTES_PER_FRAME; k++) begin
      if (byte_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s_missing: byte %0d absent", name, k);
      end else begin
        b = byte_q.pop_front();
        void'(cyc_q.pop_front());
        check($sformatf("%s_b%0d", name, k), {24'h0, b}, {24'h0, exp[k]});
      end
    end
  endtask

  task automatic check_contiguous(input string name, input int n);
    for (int i = 1; i < n && i < cyc_q.size(); i++)
      check($sformatf("%s_gap%0d", name, i), cyc_q[i], cyc_q[i-1] + 1);
  endtask

  task automatic clear_q();
    byte_q.delete();
    cyc_q.delete();
  endtask

  initial begin
    vecs[0] = '{addr: 8'h12, data: 32'hDEADBEEF, sum: 8'h30};
    vecs[1] = '{addr: 8'h00, data: 32'h00000000, sum: 8'h00};
    vecs[2] = '{addr: 8'hFF, data: 32'hFFFFFFFF, sum: 8'hFF};
    vecs[3] = '{addr: 8'h5A, data: 32'h01020304, sum: 8'h5E};
    vecs[4] = '{addr: 8'hA5, data: 32'h12345678, sum: 8'hAD};

    bus.addr = '0;
    bus.data = '0;
    bus.valid = 1'b0;

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_ready", bus.ready, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    rstn = 1'b1;
    @(negedge clk);
    check("ready_after_rst", bus.ready, 1);

    // Reset mid-frame, after the address byte has gone.
    tx_ready = 1'b1;
    push_word(8'h77, 32'hCAFEF00D);
    wait_bytes(2, 20);
    rstn = 1'b0;
    @(negedge clk);
    check("midrst_tx_valid", tx_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_frame_cnt", frame_cnt, 0);
    rstn = 1'b1;
    @(negedge clk);
    clear_q();

    // Single frames from the table, tx_ready held high.
    for (int i = 0; i < 5; i++) begin
      push_word(vecs[i].addr, vecs[i].data);
      check($sformatf("v%0d_lat_n1", i), tx_valid, 0);
      @(negedge clk);
      check($sformatf("v%0d_lat_valid", i), tx_valid, 1);
      check($sformatf("v%0d_lat_hdr", i), tx_data, HEADER_DEFAULT);
      wait_bytes(BYTES_PER_FRAME, 40);
      check_contiguous($sformatf("v%0d", i), BYTES_PER_FRAME);
      check_frame($sformatf("v%0d", i), vecs[i].addr, vecs[i].data, vecs[i].sum);
      exp_frames++;
      repeat (2) @(negedge clk);
      check($sformatf("v%0d_busy", i), busy, 0);
      check($sformatf("v%0d_cnt", i), frame_cnt, exp_frames);
    end

    // Backpressure: tx_ready toggles every cycle.
    clear_q();
    tx_ready = 1'b0;
    push_word(8'h3C, 32'h89ABCDEF);
    for (int k = 0; k < 60 && byte_q.size() < BYTES_PER_FRAME; k++) begin
      tx_ready = ~tx_ready;
      @(negedge clk);
    end
    tx_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("bp_nbytes", byte_q.size(), BYTES_PER_FRAME);
    check_frame("bp", 8'h3C, 32'h89ABCDEF, model_sum(8'h3C, 32'h89ABCDEF));
    exp_frames++;
    check("bp_cnt", frame_cnt, exp_frames);

    // Fill: one word in the frame register plus a full FIFO.
    clear_q();
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++)
      push_word(8'h30 + 8'(i), {8'h10 + 8'(i), 8'h20 + 8'(i), 8'h40 + 8'(i), 8'h80 + 8'(i)});
    bus.valid = 1'b1;
    bus.addr  = 8'hEE;
    repeat (3) begin
      check("full_ready", bus.ready, 0);
      @(negedge clk);
    end
    bus.valid = 1'b0;
    check("full_busy", busy, 1);
    check("full_no_bytes", byte_q.size(), 0);
    tx_ready = 1'b1;
    wait_bytes(9 * BYTES_PER_FRAME, 200);
    check_contiguous("full", 9 * BYTES_PER_FRAME);
    for (int i = 0; i < 9; i++) begin
      logic [7:0]  a;
      logic [31:0] d;
      a = 8'h30 + 8'(i);
      d = {8'h10 + 8'(i), 8'h20 + 8'(i), 8'h40 + 8'(i), 8'h80 + 8'(i)};
      check_frame($sformatf("full%0d", i), a, d, model_sum(a, d));
    end
    exp_frames += 9;
    repeat (3) @(negedge clk);
    check("full_cnt", frame_cnt, exp_frames);
    check("full_extra", byte_q.size(), 0);

    // Push lands on the same edge as the SUM-accept pop with one word queued.
    clear_q();
    tx_ready = 1'b0;
    push_word(8'hA1, 32'h11223344);
    push_word(8'hB2, 32'h55667788);
    tx_ready = 1'b1;
    repeat (6) @(negedge clk);
    check("sim_pre_sum", tx_data, model_sum(8'hA1, 32'h11223344));
    push_word(8'hC3, 32'h99AABBCC);
    check("sim_count", dut.u_fifo.count, 1);
    wait_bytes(3 * BYTES_PER_FRAME, 100);
    check_frame("simA", 8'hA1, 32'h11223344, model_sum(8'hA1, 32'h11223344));
    check_frame("simB", 8'hB2, 32'h55667788, model_sum(8'hB2, 32'h55667788));
    check_frame("simC", 8'hC3, 32'h99AABBCC, model_sum(8'hC3, 32'h99AABBCC));
    exp_frames += 3;
    repeat (3) @(negedge clk);
    check("sim_cnt", frame_cnt, exp_frames);
    check("sim_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end
endmodule
